// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// KEY_LEGEND is consulted only in builds with KEYPAD_HEXMAP_EN defined.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } state_t;

    // All columns released; a driven column is this value with one bit cleared.
    localparam logic [3:0] COL_IDLE = 4'b1111;

    // Legend indexed by the raw code {row[1:0], col[1:0]}; '*' is E and '#' is F.
    localparam logic [3:0] KEY_LEGEND [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

endpackage

// File: rtl/keypad_scanner_if.sv
// Key-event bus from the keypad scanner to the calculator core.
interface keypad_scanner_if;

    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (output key_code, output key_valid, output key_held);
    modport slave  (input  key_code, input  key_valid, input  key_held);

endinterface

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for asynchronous pad inputs (keypad rows by default).
module keypad_row_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta_p0;
    logic [WIDTH-1:0] sync_p1;

    // Stage p0 may go metastable; p1 is the first value safe to use.
    always_ff @(posedge clk) begin
        meta_p0 <= async_in;
        sync_p1 <= meta_p0;
    end

    assign sync_out = sync_p1;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, row debounce, one strobe per accepted press.
// Define KEYPAD_HEXMAP_EN to emit legend values instead of raw {row,col} codes.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int CLK_DIV        = 1000,
    parameter int DEBOUNCE_TICKS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        IO_P4_ROW,
    output logic [3:0]        IO_P4_COL,
    keypad_scanner_if.master  key_if
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DEB_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_TICKS - 1);

    function automatic logic [1:0] lowest_row(input logic [3:0] rows_n);
        if (!rows_n[0])      return 2'd0;
        else if (!rows_n[1]) return 2'd1;
        else if (!rows_n[2]) return 2'd2;
        else                 return 2'd3;
    endfunction

    function automatic logic [3:0] encode_key(input logic [1:0] row, input logic [1:0] col);
`ifdef KEYPAD_HEXMAP_EN
        return KEY_LEGEND[{row, col}];
`else
        return {row, col};
`endif
    endfunction

    logic [3:0]       row_s;
    logic [DIV_W-1:0] tick_cnt;
    logic             tick;
    state_t           state, state_n;
    logic [1:0]       col_idx, col_n;
    logic [1:0]       key_col, key_col_n;
    logic [3:0]       row_pattern, pattern_n;
    logic [DEB_W-1:0] deb_cnt, deb_n;
    logic [DEB_W-1:0] rel_cnt, rel_n;
    logic [3:0]       key_code_q, code_n;
    logic             key_valid_q, valid_n;

    keypad_row_sync #(.WIDTH(4)) u_row_sync (
        .clk      (clk),
        .async_in (IO_P4_ROW),
        .sync_out (row_s)
    );

    assign tick = (tick_cnt == DIV_LAST);

    always_comb begin
        state_n   = state;
        col_n     = col_idx;
        key_col_n = key_col;
        pattern_n = row_pattern;
        deb_n     = deb_cnt;
        rel_n     = rel_cnt;
        code_n    = key_code_q;
        valid_n   = 1'b0;
        if (tick) begin
            unique case (state)
                SCAN: begin
                    if (!(&row_s)) begin
                        pattern_n = row_s;
                        key_col_n = col_idx;
                        deb_n     = '0;
                        state_n   = DEBOUNCE;
                    end else begin
                        col_n = col_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (row_s != row_pattern) begin
                        state_n = SCAN;
                        col_n   = col_idx + 2'd1;
                    end else if (deb_cnt == DEB_LAST) begin
                        code_n  = encode_key(lowest_row(row_pattern), key_col);
                        valid_n = 1'b1;
                        rel_n   = '0;
                        state_n = PRESSED;
                    end else begin
                        deb_n = deb_cnt + DEB_W'(1);
                    end
                end
                PRESSED: begin
                    // Any low row, not just the accepted one, restarts the release count.
                    if (&row_s) begin
                        if (rel_cnt == DEB_LAST) begin
                            state_n = SCAN;
                            col_n   = col_idx + 2'd1;
                        end else begin
                            rel_n = rel_cnt + DEB_W'(1);
                        end
                    end else begin
                        rel_n = '0;
                    end
                end
                default: state_n = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SCAN;
            tick_cnt    <= '0;
            col_idx     <= 2'd0;
            deb_cnt     <= '0;
            rel_cnt     <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
        end else begin
            state       <= state_n;
            tick_cnt    <= tick ? '0 : tick_cnt + DIV_W'(1);
            col_idx     <= col_n;
            deb_cnt     <= deb_n;
            rel_cnt     <= rel_n;
            key_code_q  <= code_n;
            key_valid_q <= valid_n;
        end
    end

    // Captured press context; only meaningful while debouncing, so no reset.
    always_ff @(posedge clk) begin
        row_pattern <= pattern_n;
        key_col     <= key_col_n;
    end

    assign IO_P4_COL        = COL_IDLE ^ (4'b0001 << col_idx);
    assign key_if.key_code  = key_code_q;
    assign key_if.key_valid = key_valid_q;
    assign key_if.key_held  = (state == PRESSED);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with a physical 4x4 key-matrix model and a key-code scoreboard.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_pins;
    logic [3:0]  col_pins;
    logic [15:0] pressed = '0;

    int n_pass  = 0;
    int n_total = 0;

    logic [3:0] sb [$];
    logic [3:0] mon_exp;
    logic       prev_valid = 1'b0;

    logic [3:0] legend_tb [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    keypad_scanner_if kif ();

    keypad_scanner #(.CLK_DIV(4), .DEBOUNCE_TICKS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .IO_P4_ROW (row_pins),
        .IO_P4_COL (col_pins),
        .key_if    (kif)
    );

    always #5 clk = ~clk;

    // A pressed key shorts its row to its column when that column is driven low.
    always_comb begin
        row_pins = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_pins[c]) row_pins[r] = 1'b0;
    end

    function automatic logic [3:0] exp_code(input int r, input int c);
`ifdef KEYPAD_HEXMAP_EN
        return legend_tb[r*4+c];
`else
        return 4'(r*4 + c);
`endif
    endfunction

    always @(negedge clk) begin
        if (kif.key_valid) begin
            n_total++;
            if (prev_valid) $display("FAIL valid_double: key_valid high on consecutive cycles, required single pulse");
            else n_pass++;
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_valid: key_code=%h, required no strobe", kif.key_code);
            end else begin
                mon_exp = sb.pop_front();
                if (kif.key_code !== mon_exp)
                    $display("FAIL key_code: got %h, required %h", kif.key_code, mon_exp);
                else n_pass++;
            end
        end
        prev_valid = kif.key_valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wait_col_start(input logic [3:0] target);
        int t = 0;
        while (col_pins == target && t < 40) begin @(negedge clk); t++; end
        while (col_pins != target && t < 40) begin @(negedge clk); t++; end
        if (t >= 40) begin
            n_total++;
            $display("FAIL col_start_timeout: col=%b, required %b", col_pins, target);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int t = 0;
        while (sb.size() != 0 && t < budget) begin @(negedge clk); t++; end
        n_total++;
        if (sb.size() != 0) begin
            $display("FAIL %s_no_valid: %0d presses outstanding, required 0", name, sb.size());
            sb.delete();
        end else n_pass++;
    endtask

    task automatic wait_release(input string name);
        int t = 0;
        while (kif.key_held && t < 60) begin @(negedge clk); t++; end
        n_total++;
        if (kif.key_held !== 1'b0) $display("FAIL %s_release: key_held=%b, required 0", name, kif.key_held);
        else n_pass++;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [3:0] exp_col;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (col_pins !== 4'b1110) $display("FAIL rst_col: got %b, required 1110", col_pins); else n_pass++;
        n_total++; if (kif.key_valid !== 1'b0) $display("FAIL rst_valid: got %b, required 0", kif.key_valid); else n_pass++;
        n_total++; if (kif.key_code !== 4'h0) $display("FAIL rst_code: got %h, required 0", kif.key_code); else n_pass++;
        n_total++; if (kif.key_held !== 1'b0) $display("FAIL rst_held: got %b, required 0", kif.key_held); else n_pass++;
        rst = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            exp_col = 4'b1111 ^ (4'b0001 << ((k / 4) % 4));
            n_total++;
            if (col_pins !== exp_col) $display("FAIL col_walk[%0d]: got %b, required %b", k, col_pins, exp_col);
            else n_pass++;
        end
    endtask

    task automatic test_clean_press;
        int lat = -1;
        wait_col_start(4'b1011);
        pressed[1*4+2] = 1'b1;
        sb.push_back(exp_code(1, 2));
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (kif.key_valid && lat < 0) lat = n;
        end
        n_total++; if (lat != 16) $display("FAIL press_latency: got %0d cycles, required 16", lat); else n_pass++;
        n_total++; if (kif.key_held !== 1'b1) $display("FAIL clean_held: got %b, required 1", kif.key_held); else n_pass++;
        wait_drain("clean", 1);
        pressed = '0;
        repeat (6) @(negedge clk);
        n_total++; if (kif.key_held !== 1'b1) $display("FAIL clean_held_early_drop: got %b, required 1", kif.key_held); else n_pass++;
        wait_release("clean");
    endtask

    task automatic test_bounce;
        wait_col_start(4'b1110);
        pressed[0] = 1'b1;
        repeat (4) @(negedge clk);
        pressed[0] = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if (col_pins !== 4'b1110) $display("FAIL bounce_col_hold: got %b, required 1110", col_pins); else n_pass++;
        repeat (2) @(negedge clk);
        n_total++; if (col_pins !== 4'b1101) $display("FAIL bounce_resume: got %b, required 1101", col_pins); else n_pass++;
        n_total++; if (kif.key_held !== 1'b0) $display("FAIL bounce_held: got %b, required 0", kif.key_held); else n_pass++;
        wait_col_start(4'b1110);
        pressed[0] = 1'b1;
        sb.push_back(exp_code(0, 0));
        wait_drain("bounce_stable", 60);
        pressed = '0;
        wait_release("bounce_stable");
    endtask

    task automatic test_hold;
        int bad = 0;
        pressed[3*4+2] = 1'b1;
        sb.push_back(exp_code(3, 2));
        wait_drain("hold", 80);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (col_pins !== 4'b1011 || kif.key_held !== 1'b1) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL hold_col: %0d cycles with col!=1011 or key_held low, required 0", bad);
        else n_pass++;
        pressed = '0;
        wait_release("hold");
    endtask

    task automatic test_two_rows;
        pressed[2*4+3] = 1'b1;
        pressed[3*4+3] = 1'b1;
        sb.push_back(exp_code(2, 3));
        wait_drain("two_rows", 80);
        pressed = '0;
        wait_release("two_rows");
    endtask

    task automatic test_reset_pressed;
        pressed[1*4+1] = 1'b1;
        sb.push_back(exp_code(1, 1));
        wait_drain("pre_reset", 80);
        n_total++; if (kif.key_held !== 1'b1) $display("FAIL rp_held: got %b, required 1", kif.key_held); else n_pass++;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (col_pins !== 4'b1110) $display("FAIL rp_col: got %b, required 1110", col_pins); else n_pass++;
        n_total++; if (kif.key_code !== 4'h0) $display("FAIL rp_code: got %h, required 0", kif.key_code); else n_pass++;
        n_total++; if (kif.key_held !== 1'b0) $display("FAIL rp_held_cleared: got %b, required 0", kif.key_held); else n_pass++;
        n_total++; if (kif.key_valid !== 1'b0) $display("FAIL rp_valid: got %b, required 0", kif.key_valid); else n_pass++;
        rst = 1'b0;
        sb.push_back(exp_code(1, 1));
        wait_drain("post_reset", 100);
        pressed = '0;
        wait_release("post_reset");
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_hold();
        test_two_rows();
        test_reset_pressed();
        n_total++;
        if (sb.size() != 0) $display("FAIL sb_leftover: %0d entries, required 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
